// File: rtl/seg7_capture_if.sv
// Bundle of the 7-segment capture signals.
//   seg_in       segment lines a..g (bit6=a), active-high
//   en_n_in      active-low digit enables, bit i = slot i
//   frame_ready  consumer ready for a frame
//   frame_valid  frame present on frame_digits/frame_err
//   frame_digits slot i nibble at [4i+3:4i]
//   frame_err    per-slot non-decodable flag
//   overrun      sticky dropped-frame flag
// master = display/consumer side, slave = capture block.
interface seg7_capture_if #(parameter int NDIG = 4);
  logic [6:0]        seg_in;
  logic [NDIG-1:0]   en_n_in;
  logic              frame_ready;
  logic              frame_valid;
  logic [4*NDIG-1:0] frame_digits;
  logic [NDIG-1:0]   frame_err;
  logic              overrun;

  modport master (output seg_in, en_n_in, frame_ready,
                  input  frame_valid, frame_digits, frame_err, overrun);
  modport slave  (input  seg_in, en_n_in, frame_ready,
                  output frame_valid, frame_digits, frame_err, overrun);
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: samples multiplexed 7-segment lines, debounces each digit
// pattern, decodes it back to BCD and emits one frame per full digit set.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    seg7_capture_if.slave (segments/enables in, frame valid/ready out)
module seg7_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_capture_if.slave  bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  // two-flop input synchronizer
  logic [6:0]      seg_s1, seg_s2;
  logic [NDIG-1:0] en_s1, en_s2;

  // debounce state
  logic [IW-1:0]   prev_idx;
  logic [6:0]      prev_seg;
  logic [CW-1:0]   cnt;

  // frame under assembly
  logic [NDIG-1:0][3:0] dig_buf;
  logic [NDIG-1:0]      err_buf, seen;

  // output registers
  logic                 fv, ovr;
  logic [NDIG-1:0][3:0] fd;
  logic [NDIG-1:0]      fe;

  logic                 samp_ok, same, acc, complete, out_free, dec_err;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt_nxt;
  logic [3:0]           dec_code;
  logic [NDIG-1:0][3:0] dig_nxt;
  logic [NDIG-1:0]      err_nxt, seen_nxt;

  always_comb begin
    samp_ok = $onehot(~en_s2);
    idx     = '0;
    for (int i = 0; i < NDIG; i++)
      if (!en_s2[i]) idx = IW'(i);

    // cnt==0 means the previous sample was idle/illegal, so treat as new
    same = samp_ok && (cnt != '0) && (idx == prev_idx) && (seg_s2 == prev_seg);
    if (!samp_ok)   cnt_nxt = '0;
    else if (same)  cnt_nxt = (cnt == CMAX) ? CMAX : cnt + 1'b1;
    else            cnt_nxt = CW'(1);

    // saturation at CMAX keeps a held pattern from being accepted twice
    acc = samp_ok && (cnt_nxt == CMAX) && (cnt != CMAX);

    dec_err = 1'b0;
    case (seg_s2)
      7'h7E:   dec_code = 4'd0;
      7'h30:   dec_code = 4'd1;
      7'h6D:   dec_code = 4'd2;
      7'h79:   dec_code = 4'd3;
      7'h33:   dec_code = 4'd4;
      7'h5B:   dec_code = 4'd5;
      7'h5F:   dec_code = 4'd6;
      7'h70:   dec_code = 4'd7;
      7'h7F:   dec_code = 4'd8;
      7'h7B:   dec_code = 4'd9;
      7'h00:   dec_code = 4'hE;
      default: begin dec_code = 4'hF; dec_err = 1'b1; end
    endcase

    dig_nxt  = dig_buf;
    err_nxt  = err_buf;
    seen_nxt = seen;
    if (acc) begin
      dig_nxt[idx]  = dec_code;
      err_nxt[idx]  = dec_err;
      seen_nxt[idx] = 1'b1;
    end
    complete = acc && (&seen_nxt);
    out_free = !fv || bus.frame_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      en_s1    <= '1;
      en_s2    <= '1;
      prev_idx <= '0;
      prev_seg <= '0;
      cnt      <= '0;
      dig_buf  <= '0;
      err_buf  <= '0;
      seen     <= '0;
      fv       <= 1'b0;
      fd       <= '0;
      fe       <= '0;
      ovr      <= 1'b0;
    end else begin
      seg_s1 <= bus.seg_in;
      seg_s2 <= seg_s1;
      en_s1  <= bus.en_n_in;
      en_s2  <= en_s1;
      cnt    <= cnt_nxt;
      if (samp_ok) begin
        prev_idx <= idx;
        prev_seg <= seg_s2;
      end
      dig_buf <= dig_nxt;
      err_buf <= err_nxt;
      if (complete) begin
        seen <= '0;
        // a frame that finds the output occupied is dropped, not queued
        if (out_free) begin
          fv <= 1'b1;
          fd <= dig_nxt;
          fe <= err_nxt;
        end else begin
          ovr <= 1'b1;
        end
      end else begin
        seen <= seen_nxt;
        if (fv && bus.frame_ready) fv <= 1'b0;
      end
    end
  end

  assign bus.frame_valid  = fv;
  assign bus.frame_digits = fd;
  assign bus.frame_err    = fe;
  assign bus.overrun      = ovr;
endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_capture_if #(.NDIG(4)) bus ();
  seg7_capture #(.NDIG(4), .STABLE_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frm_t;

  frm_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.frame_valid && bus.frame_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame got=%0h want=none", bus.frame_digits);
      end else begin
        frm_t f;
        f = q.pop_front();
        check("frame_digits", 32'(bus.frame_digits), 32'(f.d));
        check("frame_err", 32'(bus.frame_err), 32'(f.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input int idx, input logic [6:0] seg, input int n);
    logic [3:0] one;
    one = 4'b0001;
    bus.en_n_in = ~(one << idx);
    bus.seg_in  = seg;
    cyc(n);
  endtask

  task automatic idle(input int n);
    bus.en_n_in = 4'hF;
    bus.seg_in  = 7'h00;
    cyc(n);
  endtask

  task automatic scan(input logic [6:0] s0, s1, s2, s3);
    slot(0, s0, 10);
    slot(1, s1, 10);
    slot(2, s2, 10);
    slot(3, s3, 10);
    idle(6);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.seg_in      = 7'h00;
    bus.en_n_in     = 4'hF;
    bus.frame_ready = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.seg_in      = 7'($urandom);
      bus.en_n_in     = 4'($urandom);
      bus.frame_ready = 1'($urandom);
      cyc(1);
    end
    check("rst_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_digits", 32'(bus.frame_digits), 32'd0);
    check("rst_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // 2: digits 1,2,3,4 on slots 0..3
    bus.frame_ready = 1'b1;
    q.push_back('{d: 16'h4321, e: 4'b0000});
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    check("scan_consumed", 32'(q.size()), 32'd0);
    check("scan_valid_low", 32'(bus.frame_valid), 32'd0);

    // 3: too-short hold and multi-enable samples must not be accepted
    slot(0, 7'h7E, 7);
    slot(0, 7'h30, 7);
    idle(4);
    bus.en_n_in = 4'b1100;
    bus.seg_in  = 7'h7F;
    cyc(20);
    idle(4);
    slot(1, 7'h5B, 10);
    slot(2, 7'h5F, 10);
    slot(3, 7'h70, 10);
    idle(6);
    check("glitch_no_frame", 32'(bus.frame_valid), 32'd0);
    q.push_back('{d: 16'h7659, e: 4'b0000});
    slot(0, 7'h7B, 10);
    idle(6);
    check("glitch_then_frame", 32'(q.size()), 32'd0);

    // 4: blank and invalid patterns
    q.push_back('{d: 16'h8FE7, e: 4'b0100});
    scan(7'h70, 7'h00, 7'h55, 7'h7F);
    check("blank_inv_consumed", 32'(q.size()), 32'd0);

    // 5: backpressure and overrun
    bus.frame_ready = 1'b0;
    q.push_back('{d: 16'h0123, e: 4'b0000});
    scan(7'h79, 7'h6D, 7'h30, 7'h7E);
    check("bp_valid", 32'(bus.frame_valid), 32'd1);
    check("bp_digits", 32'(bus.frame_digits), 32'h0123);
    check("bp_no_overrun", 32'(bus.overrun), 32'd0);
    scan(7'h33, 7'h5B, 7'h5F, 7'h70);
    check("ovr_valid", 32'(bus.frame_valid), 32'd1);
    check("ovr_digits_held", 32'(bus.frame_digits), 32'h0123);
    check("ovr_err_held", 32'(bus.frame_err), 32'd0);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    bus.frame_ready = 1'b1;
    idle(3);
    check("ovr_drained", 32'(q.size()), 32'd0);
    check("ovr_valid_low", 32'(bus.frame_valid), 32'd0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // 6: reset after two slots, then scan in a different order
    slot(0, 7'h7E, 10);
    slot(1, 7'h30, 10);
    rst_n = 1'b0;
    idle(2);
    check("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    check("mid_rst_valid", 32'(bus.frame_valid), 32'd0);
    rst_n = 1'b1;
    idle(2);
    q.push_back('{d: 16'h3254, e: 4'b0000});
    slot(2, 7'h6D, 10);
    slot(3, 7'h79, 10);
    idle(4);
    check("mid_rst_partial", 32'(bus.frame_valid), 32'd0);
    slot(0, 7'h33, 10);
    slot(1, 7'h5B, 10);
    idle(6);

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
